// File: rtl/fetch_ngroup_pkg.sv
// Shared types and helpers for the grouped fetch stage: FSM encoding, exception code
// and MIPS kseg address decode.
package fetch_ngroup_pkg;

  typedef enum logic [1:0] {
    FNG_IDLE = 2'd0,
    FNG_WAIT = 2'd1,
    FNG_DROP = 2'd2,
    FNG_EXC  = 2'd3
  } fng_state_e;

  localparam logic [4:0] EXC_ADEL = 5'h04;

  function automatic logic in_kseg0(input logic [31:0] pc);
    return pc[31:29] == 3'b100;
  endfunction

  function automatic logic in_kseg1(input logic [31:0] pc);
    return pc[31:29] == 3'b101;
  endfunction

  // kseg0/kseg1 are unmapped windows onto the low 512 MB; everything else passes through.
  function automatic logic [31:0] phys_addr(input logic [31:0] pc);
    return (in_kseg0(pc) || in_kseg1(pc)) ? {3'b000, pc[28:0]} : pc;
  endfunction

endpackage

// File: rtl/fetch_lane_sel.sv
// Combinational lane selection for one fetch group: lane count, emit mask, first taken lane
// and whether the taken branch redirects now or leaves its delay slot for the next group.
module fetch_lane_sel
  import fetch_ngroup_pkg::*;
#(
  parameter int FETCH_W    = 2,
  parameter int LINE_BYTES = 32,
  parameter int NW         = $clog2(FETCH_W + 1),
  parameter int KW         = (FETCH_W > 1) ? $clog2(FETCH_W) : 1,
  parameter int OFFW       = $clog2(LINE_BYTES)
) (
  input  logic [OFFW-1:0]    i_offset,
  input  logic               i_uncache,
  input  logic               i_ds_pend,
  input  logic [FETCH_W-1:0] i_bp_taken,
  output logic [NW-1:0]      o_n,
  output logic [FETCH_W-1:0] o_mask,
  output logic [KW-1:0]      o_k,
  output logic               o_redirect,
  output logic               o_ds_set
);

  int   w_words;
  int   w_n;
  int   w_k;
  int   w_emit;
  logic w_found;

  // A pending delay slot always goes out alone and suppresses any prediction on it.
  always_comb begin
    w_words = (LINE_BYTES - int'(i_offset)) / 4;
    if (i_uncache || i_ds_pend) begin
      w_n = 1;
    end else begin
      w_n = (w_words < FETCH_W) ? w_words : FETCH_W;
    end

    w_k     = 0;
    w_found = 1'b0;
    for (int i = FETCH_W - 1; i >= 0; i--) begin
      if (i_bp_taken[i] && (i < w_n)) begin
        w_k     = i;
        w_found = 1'b1;
      end
    end
    if (i_ds_pend) begin
      w_found = 1'b0;
    end

    if (w_found && (w_k + 1 < w_n)) begin
      w_emit = w_k + 2;
    end else begin
      w_emit = w_n;
    end

    o_mask = '0;
    for (int i = 0; i < FETCH_W; i++) begin
      o_mask[i] = (i < w_emit);
    end

    o_n        = NW'(w_n);
    o_k        = w_found ? KW'(w_k) : '0;
    o_redirect = w_found && (w_k + 1 < w_n);
    o_ds_set   = w_found && (w_k == w_n - 1);
  end

endmodule

// File: rtl/fetch_ngroup.sv
// Grouped IF stage: owns the fetch PC, issues one I-cache request per group and buffers one
// group toward decode. Optional macro FETCH_PERF_EN adds perf_groups/perf_drops counters.
module fetch_ngroup
  import fetch_ngroup_pkg::*;
#(
  parameter int          FETCH_W    = 2,
  parameter int          LINE_BYTES = 32,
  parameter logic [31:0] PC_RESET   = 32'hbfc00000
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  flush,
  input  logic [31:0]           flush_pc,
  output logic                  ic_req_valid,
  input  logic                  ic_req_ready,
  output logic [31:0]           ic_req_addr,
  output logic                  ic_req_uncache,
  input  logic                  ic_resp_valid,
  input  logic [32*FETCH_W-1:0] ic_resp_inst,
  input  logic [FETCH_W-1:0]    bp_taken,
  input  logic [32*FETCH_W-1:0] bp_target,
  output logic [FETCH_W-1:0]    out_valid,
  output logic [31:0]           out_pc,
  output logic [32*FETCH_W-1:0] out_inst,
  output logic [FETCH_W-1:0]    out_taken,
  output logic [32*FETCH_W-1:0] out_pd_pc,
  output logic                  out_ex,
  output logic [4:0]            out_excode,
  input  logic                  out_ready
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]           perf_groups,
  output logic [31:0]           perf_drops
`endif
);

  localparam int NW   = $clog2(FETCH_W + 1);
  localparam int KW   = (FETCH_W > 1) ? $clog2(FETCH_W) : 1;
  localparam int OFFW = $clog2(LINE_BYTES);

  fng_state_e            r_state;
  fng_state_e            w_next_state;
  logic [31:0]           r_pc;
  logic [31:0]           w_next_pc;
  logic [31:0]           r_saved_tgt;
  logic [31:0]           w_next_tgt;
  logic                  r_ds_pend;
  logic                  w_next_ds;

  logic [FETCH_W-1:0]    r_out_valid;
  logic [FETCH_W-1:0]    r_out_taken;
  logic [31:0]           r_out_pc;
  logic [32*FETCH_W-1:0] r_out_inst;
  logic [32*FETCH_W-1:0] r_out_pd_pc;
  logic                  r_out_ex;
  logic [4:0]            r_out_excode;

  logic                  w_misalign;
  logic                  w_buf_free;
  logic                  w_fire;
  logic                  w_req_fire;
  logic                  w_accept_resp;
  logic                  w_drop_resp;
  logic                  w_enter_exc;
  logic [32*FETCH_W-1:0] w_inst_masked;
  logic [31:0]           w_tgt_k;

  logic [NW-1:0]         w_n;
  logic [FETCH_W-1:0]    w_mask;
  logic [KW-1:0]         w_k;
  logic                  w_redirect;
  logic                  w_ds_set;

  assign w_misalign     = (r_pc[1:0] != 2'b00);
  assign w_fire         = r_out_valid[0] & out_ready;
  assign w_buf_free     = ~r_out_valid[0] | out_ready;
  assign ic_req_valid   = resetn & (r_state == FNG_IDLE) & ~flush & ~w_misalign & w_buf_free;
  assign ic_req_addr    = phys_addr(r_pc);
  assign ic_req_uncache = in_kseg1(r_pc);
  assign w_req_fire     = ic_req_valid & ic_req_ready;
  assign w_accept_resp  = ic_resp_valid & ~flush & (r_state == FNG_WAIT);
  assign w_drop_resp    = ic_resp_valid & ((r_state == FNG_DROP) | ((r_state == FNG_WAIT) & flush));
  assign w_enter_exc    = (r_state == FNG_IDLE) & ~flush & w_misalign & w_buf_free;
  assign w_tgt_k        = bp_target[32*int'(w_k) +: 32];

  fetch_lane_sel #(
    .FETCH_W    (FETCH_W),
    .LINE_BYTES (LINE_BYTES),
    .NW         (NW),
    .KW         (KW),
    .OFFW       (OFFW)
  ) u_lane_sel (
    .i_offset   (r_pc[OFFW-1:0]),
    .i_uncache  (in_kseg1(r_pc)),
    .i_ds_pend  (r_ds_pend),
    .i_bp_taken (bp_taken),
    .o_n        (w_n),
    .o_mask     (w_mask),
    .o_k        (w_k),
    .o_redirect (w_redirect),
    .o_ds_set   (w_ds_set)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= FNG_IDLE;
      r_pc        <= PC_RESET;
      r_saved_tgt <= '0;
      r_ds_pend   <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_pc        <= w_next_pc;
      r_saved_tgt <= w_next_tgt;
      r_ds_pend   <= w_next_ds;
    end
  end

  // A flush while a request is outstanding must still swallow its response, unless it arrives now.
  always_comb begin
    w_next_state = r_state;
    if (flush) begin
      if ((r_state == FNG_WAIT || r_state == FNG_DROP) && !w_drop_resp) begin
        w_next_state = FNG_DROP;
      end else begin
        w_next_state = FNG_IDLE;
      end
    end else begin
      case (r_state)
        FNG_IDLE: begin
          if (w_enter_exc) begin
            w_next_state = FNG_EXC;
          end else if (w_req_fire) begin
            w_next_state = FNG_WAIT;
          end
        end
        FNG_WAIT: if (w_accept_resp) w_next_state = FNG_IDLE;
        FNG_DROP: if (w_drop_resp) w_next_state = FNG_IDLE;
        FNG_EXC:  w_next_state = FNG_EXC;
        default:  w_next_state = FNG_IDLE;
      endcase
    end
  end

  always_comb begin
    w_next_pc  = r_pc;
    w_next_ds  = r_ds_pend;
    w_next_tgt = r_saved_tgt;
    if (flush) begin
      w_next_pc = flush_pc;
      w_next_ds = 1'b0;
    end else if (w_accept_resp) begin
      if (r_ds_pend) begin
        w_next_pc = r_saved_tgt;
        w_next_ds = 1'b0;
      end else if (w_redirect) begin
        w_next_pc = w_tgt_k;
      end else begin
        w_next_pc = r_pc + (32'(w_n) << 2);
        if (w_ds_set) begin
          w_next_ds  = 1'b1;
          w_next_tgt = w_tgt_k;
        end
      end
    end
  end

  always_comb begin
    w_inst_masked = '0;
    for (int i = 0; i < FETCH_W; i++) begin
      if (w_mask[i]) begin
        w_inst_masked[32*i +: 32] = ic_resp_inst[32*i +: 32];
      end
    end
  end

  // Single-entry output buffer; requests are only issued when it will be free by response time.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_out_valid  <= '0;
      r_out_taken  <= '0;
      r_out_pc     <= '0;
      r_out_inst   <= '0;
      r_out_pd_pc  <= '0;
      r_out_ex     <= 1'b0;
      r_out_excode <= '0;
    end else if (flush) begin
      r_out_valid  <= '0;
      r_out_taken  <= '0;
      r_out_pc     <= '0;
      r_out_inst   <= '0;
      r_out_pd_pc  <= '0;
      r_out_ex     <= 1'b0;
      r_out_excode <= '0;
    end else if (w_accept_resp) begin
      r_out_valid  <= w_mask;
      r_out_taken  <= bp_taken & w_mask;
      r_out_pc     <= r_pc;
      r_out_inst   <= w_inst_masked;
      r_out_pd_pc  <= bp_target;
      r_out_ex     <= 1'b0;
      r_out_excode <= '0;
    end else if (w_enter_exc) begin
      r_out_valid  <= FETCH_W'(1);
      r_out_taken  <= '0;
      r_out_pc     <= r_pc;
      r_out_inst   <= '0;
      r_out_pd_pc  <= '0;
      r_out_ex     <= 1'b1;
      r_out_excode <= EXC_ADEL;
    end else if (w_fire) begin
      r_out_valid  <= '0;
      r_out_taken  <= '0;
      r_out_pc     <= '0;
      r_out_inst   <= '0;
      r_out_pd_pc  <= '0;
      r_out_ex     <= 1'b0;
      r_out_excode <= '0;
    end
  end

  assign out_valid  = r_out_valid;
  assign out_taken  = r_out_taken;
  assign out_pc     = r_out_pc;
  assign out_inst   = r_out_inst;
  assign out_pd_pc  = r_out_pd_pc;
  assign out_ex     = r_out_ex;
  assign out_excode = r_out_excode;

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_groups;
  logic [31:0] r_perf_drops;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_perf_groups <= '0;
      r_perf_drops  <= '0;
    end else begin
      if (w_fire)      r_perf_groups <= r_perf_groups + 32'd1;
      if (w_drop_resp) r_perf_drops  <= r_perf_drops + 32'd1;
    end
  end

  assign perf_groups = r_perf_groups;
  assign perf_drops  = r_perf_drops;
`endif

endmodule

// File: tb/tb_fetch_ngroup.sv
// Directed bench for fetch_ngroup (FETCH_W=2, LINE_BYTES=32): a vector table of single-group
// fetches plus hand sequences for delay slots, flush/drop, backpressure and address errors.
module tb_fetch_ngroup;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = '0;
  logic        ic_req_valid;
  logic        ic_req_ready = 1'b0;
  logic [31:0] ic_req_addr;
  logic        ic_req_uncache;
  logic        ic_resp_valid = 1'b0;
  logic [63:0] ic_resp_inst = '0;
  logic [1:0]  bp_taken = '0;
  logic [63:0] bp_target = '0;
  logic [1:0]  out_valid;
  logic [31:0] out_pc;
  logic [63:0] out_inst;
  logic [1:0]  out_taken;
  logic [63:0] out_pd_pc;
  logic        out_ex;
  logic [4:0]  out_excode;
  logic        out_ready = 1'b1;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_groups;
  logic [31:0] perf_drops;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_ngroup #(
    .FETCH_W    (2),
    .LINE_BYTES (32),
    .PC_RESET   (32'hbfc00000)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .flush          (flush),
    .flush_pc       (flush_pc),
    .ic_req_valid   (ic_req_valid),
    .ic_req_ready   (ic_req_ready),
    .ic_req_addr    (ic_req_addr),
    .ic_req_uncache (ic_req_uncache),
    .ic_resp_valid  (ic_resp_valid),
    .ic_resp_inst   (ic_resp_inst),
    .bp_taken       (bp_taken),
    .bp_target      (bp_target),
    .out_valid      (out_valid),
    .out_pc         (out_pc),
    .out_inst       (out_inst),
    .out_taken      (out_taken),
    .out_pd_pc      (out_pd_pc),
    .out_ex         (out_ex),
    .out_excode     (out_excode),
    .out_ready      (out_ready)
`ifdef FETCH_PERF_EN
   ,.perf_groups    (perf_groups),
    .perf_drops     (perf_drops)
`endif
  );

  typedef struct {
    logic [31:0] pc;
    logic [1:0]  taken;
    logic [31:0] tgt0;
    logic [31:0] tgt1;
    logic [31:0] addr;
    logic        unc;
    logic [1:0]  valid;
    logic [31:0] nextAddr;
  } vec_t;

  vec_t vecs[10];

  function automatic logic [31:0] instWord(input logic [31:0] pc, input int lane);
    return (pc + 32'(4 * lane)) ^ 32'hA5000000;
  endfunction

  function automatic logic [63:0] expInst(input logic [31:0] pc, input logic [1:0] valid);
    logic [63:0] r;
    r = '0;
    if (valid[0]) r[31:0]  = instWord(pc, 0);
    if (valid[1]) r[63:32] = instWord(pc, 1);
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic doFlush(input logic [31:0] pc);
    flush        = 1'b1;
    flush_pc     = pc;
    ic_req_ready = 1'b0;
    ic_resp_valid = 1'b0;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic acceptReq();
    ic_req_ready = 1'b1;
    @(negedge clk);
    ic_req_ready = 1'b0;
  endtask

  task automatic respond(input logic [1:0] tk, input logic [31:0] t0, input logic [31:0] t1,
                         input logic [31:0] pc);
    ic_resp_valid = 1'b1;
    ic_resp_inst  = {instWord(pc, 1), instWord(pc, 0)};
    bp_taken      = tk;
    bp_target     = {t1, t0};
    @(negedge clk);
    ic_resp_valid = 1'b0;
    bp_taken      = '0;
  endtask

  // One group from a fresh redirect: request address, buffered group, then the follow-on request.
  task automatic applyStimulus(input vec_t v, input int idx);
    doFlush(v.pc);
    #1;
    checkOutput($sformatf("v%0d req_valid", idx), ic_req_valid, 1);
    checkOutput($sformatf("v%0d req_addr", idx), ic_req_addr, v.addr);
    checkOutput($sformatf("v%0d uncache", idx), ic_req_uncache, v.unc);
    acceptReq();
    respond(v.taken, v.tgt0, v.tgt1, v.pc);
    #1;
    checkOutput($sformatf("v%0d out_valid", idx), out_valid, v.valid);
    checkOutput($sformatf("v%0d out_pc", idx), out_pc, v.pc);
    checkOutput($sformatf("v%0d out_inst", idx), out_inst, expInst(v.pc, v.valid));
    checkOutput($sformatf("v%0d out_taken", idx), out_taken, v.taken & v.valid);
    checkOutput($sformatf("v%0d out_pd_pc", idx), out_pd_pc, {v.tgt1, v.tgt0});
    checkOutput($sformatf("v%0d next_valid", idx), ic_req_valid, 1);
    checkOutput($sformatf("v%0d next_addr", idx), ic_req_addr, v.nextAddr);
  endtask

  initial begin
    vecs[0] = '{32'h80000000, 2'b00, 32'h0, 32'h0, 32'h00000000, 1'b0, 2'b11, 32'h00000008};
    vecs[1] = '{32'h80000008, 2'b00, 32'h0, 32'h0, 32'h00000008, 1'b0, 2'b11, 32'h00000010};
    vecs[2] = '{32'h8000001C, 2'b00, 32'h0, 32'h0, 32'h0000001C, 1'b0, 2'b01, 32'h00000020};
    vecs[3] = '{32'h80000004, 2'b10, 32'h0, 32'h80000100, 32'h00000004, 1'b0, 2'b11, 32'h0000000C};
    vecs[4] = '{32'h80000000, 2'b01, 32'h80000200, 32'h0, 32'h00000000, 1'b0, 2'b11, 32'h00000200};
    vecs[5] = '{32'hBFC00000, 2'b00, 32'h0, 32'h0, 32'h1FC00000, 1'b1, 2'b01, 32'h1FC00004};
    vecs[6] = '{32'hBFC00004, 2'b11, 32'hBFC00040, 32'h0, 32'h1FC00004, 1'b1, 2'b01, 32'h1FC00008};
    vecs[7] = '{32'h00400000, 2'b00, 32'h0, 32'h0, 32'h00400000, 1'b0, 2'b11, 32'h00400008};
    vecs[8] = '{32'hFFFFFFF8, 2'b00, 32'h0, 32'h0, 32'hFFFFFFF8, 1'b0, 2'b11, 32'h00000000};
    vecs[9] = '{32'h8000001C, 2'b01, 32'h80000500, 32'h0, 32'h0000001C, 1'b0, 2'b01, 32'h00000020};

    #1;
    checkOutput("rst req_valid", ic_req_valid, 0);
    checkOutput("rst out_valid", out_valid, 0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    #1;
    checkOutput("rst out_valid after", out_valid, 0);
    checkOutput("rst out_ex", out_ex, 0);
    checkOutput("rst out_pc", out_pc, 0);
    checkOutput("rst req_valid after", ic_req_valid, 1);
    checkOutput("rst req_addr", ic_req_addr, 32'h1FC00000);
    checkOutput("rst uncache", ic_req_uncache, 1);

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i], i);
    end

    // Delay slot: taken branch in the last lane, slot fetched alone, then redirect.
    doFlush(32'h80000004);
    acceptReq();
    respond(2'b10, 32'h0, 32'h80000100, 32'h80000004);
    #1;
    checkOutput("ds first valid", out_valid, 2'b11);
    checkOutput("ds slot addr", ic_req_addr, 32'h0000000C);
    acceptReq();
    respond(2'b11, 32'h80000300, 32'h80000400, 32'h8000000C);
    #1;
    checkOutput("ds slot valid", out_valid, 2'b01);
    checkOutput("ds slot pc", out_pc, 32'h8000000C);
    checkOutput("ds slot inst", out_inst, expInst(32'h8000000C, 2'b01));
    checkOutput("ds target addr", ic_req_addr, 32'h00000100);

    // Flush while waiting: the stale response must vanish.
    doFlush(32'h80000000);
    acceptReq();
    flush    = 1'b1;
    flush_pc = 32'h80001000;
    @(negedge clk);
    flush = 1'b0;
    #1;
    checkOutput("drop req_valid", ic_req_valid, 0);
    checkOutput("drop out_valid", out_valid, 0);
    respond(2'b00, 32'h0, 32'h0, 32'h80000000);
    #1;
    checkOutput("drop resp out_valid", out_valid, 0);
    checkOutput("drop next valid", ic_req_valid, 1);
    checkOutput("drop next addr", ic_req_addr, 32'h00001000);

    // Flush coincident with the response.
    acceptReq();
    flush         = 1'b1;
    flush_pc      = 32'h80002000;
    ic_resp_valid = 1'b1;
    @(negedge clk);
    flush         = 1'b0;
    ic_resp_valid = 1'b0;
    #1;
    checkOutput("coinc out_valid", out_valid, 0);
    checkOutput("coinc req_valid", ic_req_valid, 1);
    checkOutput("coinc req_addr", ic_req_addr, 32'h00002000);

    // Backpressure: the buffered group holds and blocks further requests.
    out_ready = 1'b0;
    doFlush(32'h80000010);
    acceptReq();
    respond(2'b00, 32'h0, 32'h0, 32'h80000010);
    #1;
    checkOutput("bp out_valid", out_valid, 2'b11);
    checkOutput("bp req blocked", ic_req_valid, 0);
    @(negedge clk);
    #1;
    checkOutput("bp hold valid", out_valid, 2'b11);
    checkOutput("bp hold pc", out_pc, 32'h80000010);
    checkOutput("bp still blocked", ic_req_valid, 0);
    out_ready = 1'b1;
    #1;
    checkOutput("bp release valid", ic_req_valid, 1);
    checkOutput("bp release addr", ic_req_addr, 32'h00000018);
    @(negedge clk);
    #1;
    checkOutput("bp drained", out_valid, 0);

    // Misaligned redirect: one AdEL group, no cache traffic until the next flush.
    out_ready = 1'b0;
    doFlush(32'h80000002);
    #1;
    checkOutput("exc no req", ic_req_valid, 0);
    @(negedge clk);
    #1;
    checkOutput("exc out_valid", out_valid, 2'b01);
    checkOutput("exc out_ex", out_ex, 1);
    checkOutput("exc excode", out_excode, 5'h04);
    checkOutput("exc out_pc", out_pc, 32'h80000002);
    checkOutput("exc out_inst", out_inst, 0);
    repeat (3) @(negedge clk);
    #1;
    checkOutput("exc hold valid", out_valid, 2'b01);
    checkOutput("exc hold ex", out_ex, 1);
    checkOutput("exc hold no req", ic_req_valid, 0);
    out_ready = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("exc consumed", out_valid, 0);
    checkOutput("exc consumed ex", out_ex, 0);
    @(negedge clk);
    #1;
    checkOutput("exc stays quiet", ic_req_valid, 0);
    checkOutput("exc no regroup", out_valid, 0);
    doFlush(32'h80000000);
    #1;
    checkOutput("exc exit req", ic_req_valid, 1);
    checkOutput("exc exit addr", ic_req_addr, 32'h00000000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
